// File: rtl/adder_pkg.sv
// Shared definitions for the adder/subtractor and its flag consumers.
//   ADDER_WIDTH : default operand/result width in bits
//   flags_t     : packed {c, v, z} condition flags, reused by ALU and branch logic
package adder_pkg;

  localparam int ADDER_WIDTH = 64;

  typedef struct packed {
    logic c;  // carry out of MSB (subtract: 1 = no borrow)
    logic v;  // signed overflow
    logic z;  // result is zero
  } flags_t;

endpackage

// File: rtl/adder_cla4.sv
// 4-bit carry-lookahead slice.
//   a, b : 4-bit operands (b already inverted for subtraction by the caller)
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   cout : carry out of bit 3
//   c3   : carry into bit 3, used for the overflow flag in the top slice
module adder_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       c3
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum-of-products of g/p/cin, so none waits on
  // the carry of the bit below it.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s  = p ^ c;
  assign c3 = c[3];

endmodule

// File: rtl/adder.sv
// Two's-complement adder/subtractor with combinational and registered outputs.
//   clk            : system clock; registered outputs update on rising edge
//   rst            : asynchronous active-low reset; clears registered outputs
//   A, B           : operands
//   M              : 0 = A+B, 1 = A-B
//   S, C, V, Z     : combinational result and flags (independent of clk/rst)
//   S_q, C_q, V_q, Z_q : the same values registered one cycle later
// WIDTH must be a multiple of 4 (one lookahead slice per nibble).
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             M,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic [WIDTH-1:0] S_q,
  output logic             C_q,
  output logic             V_q,
  output logic             Z_q
);

  localparam int NSLICE = WIDTH / 4;

  logic [WIDTH-1:0]  b_eff;
  logic [NSLICE:0]   carry;
  logic [NSLICE-1:0] c3_s;
  flags_t            flags_d;

  // Subtraction is A + ~B + 1: invert B and feed M in as the carry-in.
  assign b_eff    = B ^ {WIDTH{M}};
  assign carry[0] = M;

  // Slices are rippled block-to-block through carry[].
  generate
    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
      adder_cla4 u_cla4 (
        .a    (A[4*gi +: 4]),
        .b    (b_eff[4*gi +: 4]),
        .cin  (carry[gi]),
        .s    (S[4*gi +: 4]),
        .cout (carry[gi+1]),
        .c3   (c3_s[gi])
      );
    end
    // Only the top slice's carry-into-bit-3 (the carry into the MSB) matters.
    if (NSLICE > 1) begin : g_lower_c3
      logic unused_c3;
      assign unused_c3 = ^c3_s[NSLICE-2:0];
    end
  endgenerate

  assign C = carry[NSLICE];
  assign V = c3_s[NSLICE-1] ^ carry[NSLICE];
  assign Z = ~|S;

  assign flags_d = '{c: C, v: V, z: Z};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      S_q <= '0;
      C_q <= 1'b0;
      V_q <= 1'b0;
      Z_q <= 1'b0;
    end else begin
      S_q <= S;
      C_q <= flags_d.c;
      V_q <= flags_d.v;
      Z_q <= flags_d.z;
    end
  end

endmodule

// File: tb/tb_adder.sv
module tb_adder;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] A, B;
  logic         M;
  logic [W-1:0] S, S_q;
  logic         C, V, Z, C_q, V_q, Z_q;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  adder #(.WIDTH(W)) dut (
    .clk (clk), .rst (rst),
    .A   (A),   .B   (B),   .M (M),
    .S   (S),   .C   (C),   .V (V), .Z (Z),
    .S_q (S_q), .C_q (C_q), .V_q (V_q), .Z_q (Z_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: registered outputs are valid 1ns after each rising edge that
  // followed an issued vector.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("S_q", S_q, e.s);
      chk("C_q", W'(C_q), W'(e.c));
      chk("V_q", W'(V_q), W'(e.v));
      chk("Z_q", W'(Z_q), W'(e.z));
    end
  end

  // Drive one vector, check combinational outputs, queue the registered expectation.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                       input logic [W-1:0] es, input logic ec, input logic ev,
                       input logic ez, input bit show);
    exp_t e;
    @(negedge clk);
    A = a; B = b; M = m;
    #1;
    chk("S", S, es);
    chk("C", W'(C), W'(ec));
    chk("V", W'(V), W'(ev));
    chk("Z", W'(Z), W'(ez));
    e.s = es; e.c = ec; e.v = ev; e.z = ez;
    exp_q.push_back(e);
    if (show)
      $display("vec A=%h B=%h M=%0d -> S=%h C=%0d V=%0d Z=%0d", a, b, m, S, C, V, Z);
  endtask

  // Behavioural reference: wide arithmetic plus sign-rule overflow.
  task automatic apply_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic [W:0]   full;
    logic [W-1:0] beff;
    logic         v;
    beff = m ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + (W+1)'(m);
    v    = (a[W-1] == beff[W-1]) && (full[W-1] != a[W-1]);
    apply(a, b, m, full[W-1:0], full[W], v, full[W-1:0] == '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b0; A = '0; B = '0; M = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst S_q", S_q, '0);
    chk("rst flags", W'({C_q, V_q, Z_q}), '0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors, hand-computed.
    apply(64'h0, 64'h4, 1'b0, 64'h4, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(64'h4, 64'h4, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    apply(64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    apply(64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(64'h1234, 64'h1234, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    apply(64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    apply(64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(64'h0FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h1000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    apply(64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    apply(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1);

    // Random vectors against the behavioural model.
    for (int i = 0; i < 1000; i++)
      apply_model({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

    // Reset mid-operation.
    apply(64'h4, 64'h4, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    chk("pre-rst S_q", S_q, 64'h8);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst S_q", S_q, '0);
    chk("async rst flags", W'({C_q, V_q, Z_q}), '0);
    chk("rst S comb", S, 64'h8);
    A = 64'd3; B = 64'd5; M = 1'b1;
    #1;
    chk("rst S tracks", S, 64'hFFFF_FFFF_FFFF_FFFE);
    @(posedge clk);
    #1;
    chk("held rst S_q", S_q, '0);
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");
    apply(64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
